req_encoder16_4: RTL
====================

Name: req_encoder16_4

Overview:
- Registered 16-to-4 request encoder. It accumulates 16 request lines into a sticky pending register.
- It presents one pending request at a time as a 4-bit index, using a valid/ack handshake.
- Its consumer selects the decoder/control source by index.
- Inverse companion of the 4-to-16 decode path, used by the single-cycle CPU for interrupt and event source selection.

Parameters:
- RR, 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin, search starts at last granted index + 1, mod 16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_in  in  16  request lines, sampled every rising edge; a high bit sets the matching pending bit
- clear  in  1  synchronous flush of all state
- enc_ack  in  1  consumer accepts the presented index; meaningful only while enc_valid=1
- enc_valid  out  1  enc_out holds a valid pending index
- enc_out  out  4  encoded index of the presented request
- pend_out  out  16  current pending register
- multi  out  1  more than one pending bit set (combinational from pending)
- overrun  out  1  sticky flag: a request arrived for an already-pending bit

Behaviour:
- Reset (async, rst=1): pending=0, enc_valid=0, enc_out=0, rr_ptr=0, overrun=0, therefore multi=0.
- State machine, two states:
  - IDLE (enc_valid=0).
  - PRESENT (enc_valid=1). enc_out and enc_valid are registered.
- Pending update at every edge, clear=0:
  - pending_next = (pending & ~gnt_mask) | req_in.
  - gnt_mask = onehot(enc_out) when enc_valid & enc_ack, else 0.
  - If req_in hits the bit being acked in the same cycle, the bit stays set (new request wins).
- IDLE -> PRESENT: at the edge where pending != 0, load enc_out = select(pending) and set enc_valid=1.
  - Latency: req_in high before edge E1 gives pending set after E1, and enc_valid=1 after E2.
  - req_in alone never produces valid in one edge.
- PRESENT hold: while enc_ack=0, enc_valid and enc_out stay stable, even if higher-priority bits arrive.
- PRESENT with enc_ack=1, let rem = pending & ~onehot(enc_out):
  - rem != 0: stay in PRESENT and load enc_out = select(rem) on the same edge (back-to-back, no bubble).
  - rem == 0: go to IDLE, enc_valid=0, enc_out keeps its last value.
  - Same-cycle req_in is not considered in this selection; it is picked up on the following edge.
- enc_ack while enc_valid=0: ignored, no state change.
- select(v):
  - RR=0: lowest set index.
  - RR=1: first set index scanning rr_ptr, rr_ptr+1, … wrapping 15 -> 0.
  - rr_ptr <= enc_out+1 (mod 16) on every accepted ack. Index 15 wraps the pointer to 0.
- overrun: set at an edge where req_in[i]=1 and pending[i]=1 and bit i is not being acked that edge. Sticky until clear or rst.
- clear=1 (synchronous): pending=0, enc_valid=0, enc_out=0, rr_ptr=0, overrun=0.
  - clear overrides req_in and enc_ack in the same cycle; that cycle's req_in is discarded.
- multi = (popcount(pending) > 1).
- Reset mid-handshake: immediately returns to the reset values; an outstanding ack is lost.
- All 16 bits pending: served in 16 consecutive acked cycles with no bubble. Order is 0..15 for RR=0, rotating for RR=1.

Test Plan:
- Reset/latency: rst=1 then release; pulse req_in=16'h0020 one cycle -> pend_out=0x0020 after edge 1; enc_valid=1, enc_out=5 after edge 2; multi=0.
- Fixed priority, back-to-back (RR=0): req_in=16'h8201 one cycle, hold enc_ack=1 -> enc_out sequence 0,9,15 on consecutive cycles, then enc_valid=0, pend_out=0. multi=1 until the second ack.
- Hold stability: present index 9 with ack low; inject req_in bit 2 -> enc_out stays 9 for 5 cycles; after ack, enc_out=2.
- Round-robin (RR=1): keep bits 3 and 12 permanently requested, ack every cycle -> enc_out alternates 3,12,3,12. Pointer wrap test: grant 15 then pending {0,14} -> next grant 0.
- Overrun and same-cycle ack/re-request: pending bit 4 presented; req_in bit 4 with ack -> bit 4 re-pending, overrun=0. req_in bit 7 twice before service -> overrun=1, held until clear.
- Clear priority: with enc_valid=1, assert clear, enc_ack and req_in=16'hFFFF in the same cycle -> next cycle pend_out=0, enc_valid=0, enc_out=0, overrun=0. Async rst asserted mid-cycle -> outputs zero before the next edge.

Source files
------------

// File: rtl/req_encoder16_4_if.sv
// rtl/req_encoder16_4_if.sv - request/encoded-index bundle for req_encoder16_4
//
// Purpose: groups the request inputs and the encoded-index outputs of the
// 16-to-4 request encoder.
// Signals:
//   req_in    16  request lines, a high bit sets the matching pending bit
//   clear      1  synchronous flush of all encoder state
//   enc_ack    1  consumer accepts the presented index (only while enc_valid)
//   enc_valid  1  enc_out holds a valid pending index
//   enc_out    4  encoded index of the presented request
//   pend_out  16  current pending register
//   multi      1  more than one pending bit set
//   overrun    1  sticky: a request arrived for an already-pending bit
// Modports: master = request source / consumer, slave = encoder.
interface req_encoder16_4_if;
    logic [15:0] req_in;
    logic        clear;
    logic        enc_ack;
    logic        enc_valid;
    logic [3:0]  enc_out;
    logic [15:0] pend_out;
    logic        multi;
    logic        overrun;

    modport master (
        output req_in, clear, enc_ack,
        input  enc_valid, enc_out, pend_out, multi, overrun
    );

    modport slave (
        input  req_in, clear, enc_ack,
        output enc_valid, enc_out, pend_out, multi, overrun
    );
endinterface

// File: rtl/req_encoder16_4.sv
// rtl/req_encoder16_4.sv - registered 16-to-4 request encoder with valid/ack handshake
//
// Purpose: accumulates 16 request lines into a sticky pending register and
// presents one pending request at a time as a 4-bit index.
// Parameters:
//   RR   0 = fixed priority (lowest index wins), 1 = round-robin
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  req_encoder16_4_if.slave (req_in, clear, enc_ack in;
//        enc_valid, enc_out, pend_out, multi, overrun out)
module req_encoder16_4 #(
    parameter int RR = 0
) (
    input  logic            clk,
    input  logic            rst,
    req_encoder16_4_if.slave bus
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [3:0]  enc_out_q, enc_out_d;
    logic [3:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0] pend_q, pend_d;
    logic        overrun_q, overrun_d;

    logic        accept;
    logic [15:0] gnt_mask;
    logic [15:0] rem;
    logic [3:0]  next_ptr;

    // First set bit of v scanning start, start+1, ... with 4-bit wrap.
    // Scanning from the farthest offset down lets the nearest hit win.
    function automatic logic [3:0] select_idx(input logic [15:0] v, input logic [3:0] start);
        logic [3:0] idx;
        logic [3:0] res;
        res = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (v[idx]) res = idx;
        end
        return res;
    endfunction

    always_comb begin
        accept    = (state_q == PRESENT) && bus.enc_ack;
        gnt_mask  = accept ? (16'd1 << enc_out_q) : 16'd0;
        rem       = pend_q & ~gnt_mask;
        next_ptr  = enc_out_q + 4'd1;

        state_d   = state_q;
        enc_out_d = enc_out_q;
        rr_ptr_d  = accept ? next_ptr : rr_ptr_q;
        // A request on the bit being acked re-sets it; it is not an overrun.
        pend_d    = rem | bus.req_in;
        overrun_d = overrun_q | (|(bus.req_in & rem));

        case (state_q)
            IDLE: begin
                if (pend_q != 16'd0) begin
                    state_d   = PRESENT;
                    enc_out_d = select_idx(pend_q, (RR != 0) ? rr_ptr_q : 4'd0);
                end
            end
            default: begin
                // Selection on ack uses only already-pending bits, so the
                // next index is available on the same edge with no bubble.
                if (accept) begin
                    if (rem != 16'd0) begin
                        enc_out_d = select_idx(rem, (RR != 0) ? next_ptr : 4'd0);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        if (bus.clear) begin
            state_d   = IDLE;
            enc_out_d = 4'd0;
            rr_ptr_d  = 4'd0;
            pend_d    = 16'd0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            enc_out_q <= 4'd0;
            rr_ptr_q  <= 4'd0;
            pend_q    <= 16'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            enc_out_q <= enc_out_d;
            rr_ptr_q  <= rr_ptr_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.enc_valid = (state_q == PRESENT);
    assign bus.enc_out   = enc_out_q;
    assign bus.pend_out  = pend_q;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign bus.multi     = |(pend_q & (pend_q - 16'd1));
    assign bus.overrun   = overrun_q;
endmodule
